// File: rtl/npu_result_collector.sv
// Result collector for the NPU output stream: buffers one inference worth of
// signed 8-bit class scores, tracks the running argmax and serves them on a word-addressed read port.
module npu_result_collector #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned ADDR_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        d_out,
   input  logic              d_valid,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   output logic [31:0]       readdata,
   output logic              done
);

   localparam int unsigned CNT_W     = $clog2(NUM_CLASSES + 1);
   localparam int unsigned NUM_WORDS = (NUM_CLASSES + 3) / 4;
   localparam int unsigned FLAT_W    = NUM_WORDS * 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_done;
   logic               r_overflow;
   logic [CNT_W-1:0]   r_count;
   logic [7:0]         r_score [NUM_CLASSES];
   logic [7:0]         r_max_score;
   logic [7:0]         r_max_idx;
   logic [31:0]        r_readdata;

   logic [FLAT_W-1:0]  w_flat;
   logic [31:0]        w_words [NUM_WORDS];
   logic [31:0]        w_status;
   logic [31:0]        w_argmax;
   logic [31:0]        w_addr_ext;
   logic [31:0]        w_rdata;
   logic               w_last;
   logic               w_new_max;

   // Pack scores little-endian into words; padding bytes past the last class read as zero.
   for (genvar g = 0; g < int'(NUM_WORDS * 4); g++) begin : g_pack
      if (g < int'(NUM_CLASSES)) begin : g_used
         assign w_flat[g*8 +: 8] = r_score[g];
      end else begin : g_pad
         assign w_flat[g*8 +: 8] = 8'h00;
      end
   end

   for (genvar k = 0; k < int'(NUM_WORDS); k++) begin : g_word
      assign w_words[k] = w_flat[k*32 +: 32];
   end

   assign w_status   = {16'h0000, 8'(r_count), 4'h0, 2'(r_state), r_overflow, r_done};
   assign w_argmax   = {16'h0000, r_max_idx, r_max_score};
   assign w_addr_ext = 32'(address);
   assign w_last     = (r_count == CNT_W'(NUM_CLASSES - 1));
   assign w_new_max  = ($signed(d_out) > $signed(r_max_score));

   // Read-data mux; unmapped addresses return zero.
   always_comb begin
      w_rdata = 32'h0000_0000;
      if (w_addr_ext == 32'd0) begin
         w_rdata = w_status;
      end else if (w_addr_ext == 32'd1) begin
         w_rdata = w_argmax;
      end else begin
         for (int k = 0; k < int'(NUM_WORDS); k++) begin
            if (w_addr_ext == 32'(k + 2)) begin
               w_rdata = w_words[k];
            end
         end
      end
   end

   // Control FSM, score buffer and read register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
         r_count     <= '0;
         r_max_score <= 8'h80;
         r_max_idx   <= 8'h00;
         r_readdata  <= 32'h0000_0000;
         for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            r_score[i] <= 8'h00;
         end
      end else begin
         if (read) begin
            r_readdata <= w_rdata;
         end

         // start wins over any byte presented in the same cycle.
         if (start) begin
            r_state     <= ST_COLLECT;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
            r_max_score <= 8'h80;
            r_max_idx   <= 8'h00;
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
               r_score[i] <= 8'h00;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (d_valid) begin
                     r_overflow <= 1'b1;
                  end
               end
               ST_COLLECT: begin
                  if (d_valid) begin
                     r_score[r_count] <= d_out;
                     r_count          <= r_count + CNT_W'(1);
                     if (w_new_max) begin
                        r_max_score <= d_out;
                        r_max_idx   <= 8'(r_count);
                     end
                     if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end
                  end
               end
               ST_DONE: begin
                  if (d_valid) begin
                     r_overflow <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign readdata = r_readdata;
   assign done     = r_done;

endmodule

// File: tb/tb_npu_result_collector.sv
// Scoreboard bench for npu_result_collector: reads push expected words into a
// queue, a monitor pops and compares one cycle after each read strobe.
module tb_npu_result_collector;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  d_out;
   logic        d_valid;
   logic        read;
   logic [3:0]  address;
   logic [31:0] readdata;
   logic        done;

   int          n_checks;
   int          n_fails;
   logic [31:0] exp_q [$];
   string       name_q [$];
   logic        mon_rd;

   npu_result_collector #(.NUM_CLASSES(10), .ADDR_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .d_out    (d_out),
      .d_valid  (d_valid),
      .read     (read),
      .address  (address),
      .readdata (readdata),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: readdata is valid just after the edge that sampled read.
   always @(posedge clk) begin
      mon_rd = read;
      #1;
      if (mon_rd) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
         end else begin
            check(name_q.pop_front(), readdata, exp_q.pop_front());
         end
      end
   end

   task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
      exp_q.push_back(exp);
      name_q.push_back(name);
      read    = 1'b1;
      address = addr;
      @(negedge clk);
      read    = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      d_valid = 1'b1;
      d_out   = b;
      @(negedge clk);
      d_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [7:0] vec [10];

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset    = 1'b1;
      start    = 1'b0;
      d_out    = 8'h00;
      d_valid  = 1'b0;
      read     = 1'b0;
      address  = 4'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("reset_done", 32'(done), 32'd0);
      check("reset_readdata", readdata, 32'h0);
      do_read(4'd0, 32'h0000_0000, "reset_status");
      do_read(4'd1, 32'h0000_0080, "reset_argmax");
      do_read(4'd2, 32'h0000_0000, "reset_word2");

      // Mixed-sign vector with a tie at the maximum
      vec = '{8'h05, 8'hF0, 8'h12, 8'h7F, 8'h00, 8'h7F, 8'h80, 8'h01, 8'h02, 8'h03};
      pulse_start();
      for (int i = 0; i < 9; i++) send(vec[i]);
      check("done_before_last", 32'(done), 32'd0);
      send(vec[9]);
      check("done_after_last", 32'(done), 32'd1);
      do_read(4'd0, 32'h0000_0A09, "mix_status");
      do_read(4'd1, 32'h0000_037F, "mix_argmax");
      do_read(4'd2, 32'h7F12_F005, "mix_word2");
      do_read(4'd3, 32'h0180_7F00, "mix_word3");
      do_read(4'd4, 32'h0000_0302, "mix_word4");
      do_read(4'd5, 32'h0000_0000, "mix_unmapped5");

      // Extra bytes after DONE set overflow and leave the buffer alone
      send(8'h55);
      send(8'h66);
      do_read(4'd0, 32'h0000_0A0B, "ovf_status");
      do_read(4'd2, 32'h7F12_F005, "ovf_word2");
      do_read(4'd4, 32'h0000_0302, "ovf_word4");
      pulse_start();
      check("restart_done", 32'(done), 32'd0);
      do_read(4'd0, 32'h0000_0004, "restart_status");
      do_read(4'd1, 32'h0000_0080, "restart_argmax");
      do_read(4'd2, 32'h0000_0000, "restart_word2");

      // All-negative scores: first index keeps the max on ties
      for (int i = 0; i < 10; i++) send(8'hFE);
      do_read(4'd1, 32'h0000_00FE, "neg_argmax");
      do_read(4'd0, 32'h0000_0A09, "neg_status");
      do_read(4'd2, 32'hFEFE_FEFE, "neg_word2");
      do_read(4'd4, 32'h0000_FEFE, "neg_word4");

      // Byte coinciding with start is dropped
      start   = 1'b1;
      d_valid = 1'b1;
      d_out   = 8'h40;
      @(negedge clk);
      start   = 1'b0;
      d_valid = 1'b0;
      for (int i = 0; i < 10; i++) send(8'h01);
      do_read(4'd0, 32'h0000_0A09, "drop_status");
      do_read(4'd1, 32'h0000_0001, "drop_argmax");
      do_read(4'd2, 32'h0101_0101, "drop_word2");

      // Partial collection, then reset aborts it
      pulse_start();
      send(8'h10);
      send(8'h20);
      send(8'h30);
      send(8'h40);
      do_read(4'd0, 32'h0000_0404, "partial_status");
      do_read(4'd1, 32'h0000_0340, "partial_argmax");
      do_read(4'd2, 32'h4030_2010, "partial_word2");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_done", 32'(done), 32'd0);
      check("abort_readdata", readdata, 32'h0);
      do_read(4'd0, 32'h0000_0000, "abort_status");
      do_read(4'd1, 32'h0000_0080, "abort_argmax");
      do_read(4'd2, 32'h0000_0000, "abort_word2");
      send(8'h77);
      do_read(4'd0, 32'h0000_0002, "idle_ovf_status");
      do_read(4'd2, 32'h0000_0000, "idle_ovf_word2");
      do_read(4'd15, 32'h0000_0000, "unmapped15");

      // Drain outstanding reads with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
